esc_quad: RTL and testbench

Quad ESC pulse generator sitting downstream of the flight controller. It takes the four 11-bit unsigned motor speeds plus four 10-bit per-motor calibration offsets and drives four servo-style PWM lines at a fixed frame rate. It runs an arming sequence at minimum pulse width before following commanded speeds. Pulse widths are double-buffered, so a frame in progress is never disturbed.

---
 rtl/esc_pkg.sv | 22 ++
 rtl/esc_if.sv | 35 +++
 rtl/esc_chan.sv | 50 +++++
 rtl/esc_quad.sv | 127 ++++++++++++
 tb/tb_esc_quad.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/esc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : esc_pkg
// Brief    : Shared widths and FSM state type for the quad ESC generator.
// Revision : 1.0 - initial release
// ============================================================================
package esc_pkg;

  localparam int SPD_W  = 11;  // commanded speed
  localparam int OFF_W  = 10;  // calibration offset
  localparam int COMP_W = 12;  // speed + offset, max 3070
  localparam int PW_W   = 20;  // pulse width / frame counter compare width
  localparam int N_CHAN = 4;   // front, back, left, right

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    RUN    = 2'd2
  } esc_state_t;

endpackage
`default_nettype wire

// File: rtl/esc_if.sv
`default_nettype none
// ============================================================================
// Interface: esc_if
// Brief    : Flight-controller side bundle: arm level, speeds, offsets and
//            the four PWM lines plus frame-start / armed status.
// Revision : 1.0 - initial release
// ============================================================================
interface esc_if;
  import esc_pkg::*;

  logic             arm;
  logic [SPD_W-1:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic [OFF_W-1:0] frnt_off, bck_off, lft_off, rght_off;
  logic             frnt_pwm, bck_pwm, lft_pwm, rght_pwm;
  logic             frm_strt;
  logic             armed;

  modport master (
    output arm,
    output frnt_spd, bck_spd, lft_spd, rght_spd,
    output frnt_off, bck_off, lft_off, rght_off,
    input  frnt_pwm, bck_pwm, lft_pwm, rght_pwm,
    input  frm_strt, armed
  );

  modport slave (
    input  arm,
    input  frnt_spd, bck_spd, lft_spd, rght_spd,
    input  frnt_off, bck_off, lft_off, rght_off,
    output frnt_pwm, bck_pwm, lft_pwm, rght_pwm,
    output frm_strt, armed
  );

endinterface
`default_nettype wire

// File: rtl/esc_chan.sv
`default_nettype none
// ============================================================================
// Module   : esc_chan
// Brief    : One motor channel: compensated speed to pulse width, shadow
//            width register and the registered PWM compare.
// Revision : 1.0 - initial release
// ============================================================================
module esc_chan
  import esc_pkg::*;
#(
  parameter int MIN_PULSE = 50_000,
  parameter int SCALE     = 25
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [SPD_W-1:0] i_spd,
  input  wire logic [OFF_W-1:0] i_off,
  input  wire logic             i_load,     // frame boundary / arming start
  input  wire logic             i_use_min,  // next frame is an arming frame
  input  wire logic             i_active,   // generating frames this cycle
  input  wire logic [PW_W-1:0]  i_cnt,
  output      logic             o_pwm
);

  logic [COMP_W-1:0] w_comp;
  logic [PW_W-1:0]   w_width_nxt;
  logic [PW_W-1:0]   r_width;
  logic              r_pwm;

  // Offset adds straight onto speed; 2047 + 1023 fits 12 bits, so no clamp.
  assign w_comp      = COMP_W'(i_spd) + COMP_W'(i_off);
  assign w_width_nxt = i_use_min ? PW_W'(MIN_PULSE)
                                 : PW_W'(MIN_PULSE) + PW_W'(w_comp) * PW_W'(SCALE);

  // Shadow width: only changes at a frame boundary so a running pulse is stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_width <= PW_W'(MIN_PULSE);
    else if (i_load) r_width <= w_width_nxt;
  end

  // PWM high while the frame counter is below the latched width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm <= 1'b0;
    else        r_pwm <= i_active && (i_cnt < r_width);
  end

  assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/esc_quad.sv
`default_nettype none
// ============================================================================
// Module   : esc_quad
// Brief    : Quad ESC pulse generator: arming sequence, frame counter and
//            four double-buffered servo-style PWM channels.
// Revision : 1.0 - initial release
// ============================================================================
module esc_quad
  import esc_pkg::*;
#(
  parameter int PERIOD_CYC = 1_000_000,
  parameter int MIN_PULSE  = 50_000,
  parameter int SCALE      = 25,
  parameter int ARM_FRAMES = 50
) (
  input wire logic clk,
  input wire logic rst_n,
  esc_if.slave     bus
);

  localparam int CNT_W = $clog2(PERIOD_CYC);
  localparam int FRM_W = $clog2(ARM_FRAMES + 1);

  esc_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [FRM_W-1:0] r_frm_cnt, w_frm_cnt_nxt;
  logic             w_wrap, w_load, w_active;
  logic             r_frm_strt, r_armed;
  logic [SPD_W-1:0] w_spd [N_CHAN];
  logic [OFF_W-1:0] w_off [N_CHAN];
  logic [N_CHAN-1:0] w_pwm;
  logic [PW_W-1:0]  w_cnt_ext;

  assign w_wrap    = (r_cnt == CNT_W'(PERIOD_CYC - 1));
  // Dropping arm kills outputs on the very edge it is sampled.
  assign w_active  = bus.arm && (r_state != IDLE);
  assign w_cnt_ext = PW_W'(r_cnt);

  // Next-state, counter and shadow-load decode; arm=0 beats everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_frm_cnt_nxt = r_frm_cnt;
    w_load        = 1'b0;
    if (!bus.arm) begin
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_frm_cnt_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt   = ARMING;
          w_cnt_nxt     = '0;
          w_frm_cnt_nxt = '0;
          w_load        = 1'b1;
        end
        ARMING: begin
          w_cnt_nxt = w_wrap ? '0 : r_cnt + CNT_W'(1);
          if (w_wrap) begin
            w_load        = 1'b1;
            w_frm_cnt_nxt = r_frm_cnt + FRM_W'(1);
            if (r_frm_cnt == FRM_W'(ARM_FRAMES - 1)) w_state_nxt = RUN;
          end
        end
        RUN: begin
          w_cnt_nxt = w_wrap ? '0 : r_cnt + CNT_W'(1);
          w_load    = w_wrap;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, frame counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_frm_cnt  <= '0;
      r_frm_strt <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_frm_cnt  <= w_frm_cnt_nxt;
      r_frm_strt <= w_active && (r_cnt == '0);
      r_armed    <= (w_state_nxt == RUN);
    end
  end

  assign w_spd[0] = bus.frnt_spd;
  assign w_spd[1] = bus.bck_spd;
  assign w_spd[2] = bus.lft_spd;
  assign w_spd[3] = bus.rght_spd;
  assign w_off[0] = bus.frnt_off;
  assign w_off[1] = bus.bck_off;
  assign w_off[2] = bus.lft_off;
  assign w_off[3] = bus.rght_off;

  generate
    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
      esc_chan #(
        .MIN_PULSE (MIN_PULSE),
        .SCALE     (SCALE)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_spd     (w_spd[gi]),
        .i_off     (w_off[gi]),
        .i_load    (w_load),
        .i_use_min (w_state_nxt != RUN),
        .i_active  (w_active),
        .i_cnt     (w_cnt_ext),
        .o_pwm     (w_pwm[gi])
      );
    end
  endgenerate

  assign bus.frnt_pwm = w_pwm[0];
  assign bus.bck_pwm  = w_pwm[1];
  assign bus.lft_pwm  = w_pwm[2];
  assign bus.rght_pwm = w_pwm[3];
  assign bus.frm_strt = r_frm_strt;
  assign bus.armed    = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_esc_quad.sv
`default_nettype none
// ============================================================================
// Module   : tb_esc_quad
// Brief    : Scoreboard bench for esc_quad. Stimulus pushes the expected
//            per-frame pulse widths; a monitor measures each frame and pops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_esc_quad;
  import esc_pkg::*;

  localparam int PERIOD = 4000;
  localparam int MINP   = 100;
  localparam int SCL    = 1;
  localparam int ARMF   = 2;
  localparam int TMO    = PERIOD + 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  esc_if bus();

  esc_quad #(
    .PERIOD_CYC (PERIOD),
    .MIN_PULSE  (MINP),
    .SCALE      (SCL),
    .ARM_FRAMES (ARMF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][31:0] w;
    logic             full;  // frame ends with a regular next frm_strt
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   spd_m[4];
  int   off_m[4];
  int   frame_idx = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [3:0] pwm_v();
    return {bus.rght_pwm, bus.lft_pwm, bus.bck_pwm, bus.frnt_pwm};
  endfunction

  // Reference: arming frames are always minimum width; afterwards each
  // channel follows the speed and offset present when the frame began.
  function automatic int model_width(input int idx, input int spd, input int off);
    if (idx < ARMF) return MINP;
    return MINP + (spd + off) * SCL;
  endfunction

  task automatic drive_in();
    bus.frnt_spd = SPD_W'(spd_m[0]);
    bus.bck_spd  = SPD_W'(spd_m[1]);
    bus.lft_spd  = SPD_W'(spd_m[2]);
    bus.rght_spd = SPD_W'(spd_m[3]);
    bus.frnt_off = OFF_W'(off_m[0]);
    bus.bck_off  = OFF_W'(off_m[1]);
    bus.lft_off  = OFF_W'(off_m[2]);
    bus.rght_off = OFF_W'(off_m[3]);
  endtask

  task automatic randomize_inputs();
    for (int ch = 0; ch < 4; ch++) begin
      spd_m[ch] = int'($urandom_range(0, 2047));
      off_m[ch] = int'($urandom_range(0, 1023));
    end
    drive_in();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " pwm"},      int'(pwm_v()),      0);
    check({tag, " armed"},    int'(bus.armed),    0);
    check({tag, " frm_strt"}, int'(bus.frm_strt), 0);
  endtask

  task automatic wait_strt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < PERIOD + 20; i++) begin
      @(negedge clk);
      if (bus.frm_strt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("frm_strt timeout", 0, 1);
  endtask

  // One frame: sync to frm_strt (cnt==1 at that sample), push expectation,
  // optionally change inputs at cnt==chg_at, optionally drop arm / reset at
  // cnt==drop_at (pulses then end after min(width, drop_at) cycles).
  task automatic run_frame(input int chg_at, input int new_frnt,
                           input int drop_at, input bit use_rst);
    bit   ok;
    exp_t e;
    int   w;
    int   cur;
    wait_strt(ok);
    if (!ok) return;
    check("armed at frm_strt", int'(bus.armed), (frame_idx >= ARMF) ? 1 : 0);
    e = '0;
    for (int ch = 0; ch < 4; ch++) begin
      w = model_width(frame_idx, spd_m[ch], off_m[ch]);
      if (drop_at > 0 && w > drop_at) w = drop_at;
      e.w[ch] = 32'(w);
    end
    e.full = (drop_at <= 0);
    exp_q.push_back(e);
    frame_idx++;
    cur = 1;
    if (chg_at > 1) begin
      repeat (chg_at - cur) @(negedge clk);
      cur = chg_at;
      if (new_frnt >= 0) begin
        spd_m[0] = new_frnt;
        drive_in();
      end else begin
        randomize_inputs();
      end
    end
    if (drop_at > cur) begin
      repeat (drop_at - cur) @(negedge clk);
      if (use_rst) begin
        #2;
        rst_n   = 1'b0;
        bus.arm = 1'b0;
        #1;
        check_quiet("async reset");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        bus.arm = 1'b0;
        @(negedge clk);
        check_quiet("arm drop");
      end
    end
  endtask

  task automatic idle_watch();
    int strts = 0;
    int highs = 0;
    for (int i = 0; i < PERIOD + 10; i++) begin
      @(negedge clk);
      if (bus.frm_strt) strts++;
      if (pwm_v() != 4'd0) highs++;
    end
    check("frm_strt while idle", strts, 0);
    check("pwm high while idle", highs, 0);
  endtask

  // Monitor: measures each frame between frm_strt pulses (or until a
  // timeout for aborted frames) and compares against the scoreboard.
  bit         mon_open = 1'b0;
  int         mon_cyc  = 0;
  int         mon_hi[4];
  logic [3:0] mon_pv;

  task automatic close_frame(input bit strt);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard underflow", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    for (int ch = 0; ch < 4; ch++)
      check($sformatf("pulse width ch%0d", ch), mon_hi[ch], int'(e.w[ch]));
    if (e.full) check("frame spacing", strt ? mon_cyc : -1, PERIOD);
    else        check("frm_strt after aborted frame", int'(strt), 0);
  endtask

  always @(negedge clk) begin
    mon_pv = pwm_v();
    if (bus.frm_strt) begin
      if (mon_open) close_frame(1'b1);
      check("pwm rise with frm_strt", int'(mon_pv), 15);
      mon_open = 1'b1;
      mon_cyc  = 0;
      for (int ch = 0; ch < 4; ch++) mon_hi[ch] = 0;
    end
    if (mon_open) begin
      mon_cyc++;
      for (int ch = 0; ch < 4; ch++) if (mon_pv[ch]) mon_hi[ch]++;
      if (mon_cyc >= TMO) begin
        close_frame(1'b0);
        mon_open = 1'b0;
      end
    end
  end

  initial begin
    bus.arm = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      spd_m[ch] = 0;
      off_m[ch] = 0;
    end
    drive_in();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset state");
    rst_n = 1'b1;
    @(negedge clk);

    // Session 1: directed widths, double buffering, random frames, arm drop.
    spd_m = '{500, 2047, 0, 0};
    off_m = '{0, 1023, 0, 10};
    drive_in();
    frame_idx = 0;
    bus.arm   = 1'b1;
    run_frame(0, -1, 0, 1'b0);
    run_frame(0, -1, 0, 1'b0);
    run_frame(50, 1000, 0, 1'b0);
    run_frame(0, -1, 0, 1'b0);
    for (int k = 0; k < 3; k++)
      run_frame(int'($urandom_range(2, 3990)), -1, 0, 1'b0);
    run_frame(0, -1, 300, 1'b0);
    idle_watch();

    // Session 2: re-arm with random inputs, drop arm on the last frame cycle.
    randomize_inputs();
    frame_idx = 0;
    bus.arm   = 1'b1;
    run_frame(0, -1, 0, 1'b0);
    run_frame(int'($urandom_range(2, 3990)), -1, 0, 1'b0);
    run_frame(int'($urandom_range(2, 3990)), -1, 0, 1'b0);
    run_frame(0, -1, PERIOD - 1, 1'b0);
    idle_watch();

    // Session 3: reset mid-frame, then full arming sequence again.
    frame_idx = 0;
    bus.arm   = 1'b1;
    run_frame(0, -1, 60, 1'b1);
    idle_watch();
    randomize_inputs();
    frame_idx = 0;
    bus.arm   = 1'b1;
    run_frame(0, -1, 0, 1'b0);
    run_frame(0, -1, 0, 1'b0);
    run_frame(int'($urandom_range(2, 1400)), -1, 1500, 1'b0);
    idle_watch();

    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
